// File: rtl/btn_input_fifo_pkg.sv
// Shared constants for the button-driven input FIFO.
// Defaults here are also used by the top-level board wiring.
package btn_input_fifo_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_SW_WIDTH   = 4;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_DEBOUNCE   = 4;

  function automatic int cnt_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_input_fifo_debouncer.sv
// Two-flop synchronizer, stability counter and
// rising-edge pulse for one raw button.
module btn_input_fifo_debouncer
  import btn_input_fifo_pkg::*;
#(
  parameter int DEBOUNCE = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evt
);

  localparam int CW = cnt_bits(DEBOUNCE);

  logic [1:0]    sync_q;
  logic          sync_in;
  logic          level;
  logic [CW-1:0] cnt;

  assign sync_in = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      level  <= 1'b0;
      cnt    <= '0;
      evt    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      evt    <= 1'b0;
      if (sync_in == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        // Level accepted; pulse only on the press.
        level <= sync_in;
        cnt   <= '0;
        evt   <= sync_in;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_input_fifo.sv
// Debounced push button snapshots the switches into a
// small FIFO popped by the CPU; a second button flushes it.
module btn_input_fifo
  import btn_input_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SW_WIDTH   = DEF_SW_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int DEBOUNCE   = DEF_DEBOUNCE
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn_push,
  input  logic                       btn_clear,
  input  logic [SW_WIDTH-1:0]        sw,
  input  logic                       rd_req,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int PW = cnt_bits(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  push_evt;
  logic                  clr_evt;
  logic [SW_WIDTH-1:0]   sw_s1;
  logic [SW_WIDTH-1:0]   sw_sync;
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  pop;
  logic                  push_ok;
  logic                  push_drop;

  btn_input_fifo_debouncer #(.DEBOUNCE(DEBOUNCE)) u_push_db (
    .clk (clk),
    .rst (rst),
    .raw (btn_push),
    .evt (push_evt)
  );

  btn_input_fifo_debouncer #(.DEBOUNCE(DEBOUNCE)) u_clear_db (
    .clk (clk),
    .rst (rst),
    .raw (btn_clear),
    .evt (clr_evt)
  );

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Clear wins; a pop frees a slot for a push in the same cycle.
  always_comb begin
    pop       = 1'b0;
    push_ok   = 1'b0;
    push_drop = 1'b0;
    if (!clr_evt) begin
      pop       = rd_req && !empty;
      push_ok   = push_evt && (!full || pop);
      push_drop = push_evt && !push_ok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1   <= '0;
      sw_sync <= '0;
    end else begin
      sw_s1   <= sw;
      sw_sync <= sw_s1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wp] <= DATA_WIDTH'(sw_sync);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clr_evt) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) begin
        rd_data <= mem[rp];
        rp      <= rp + 1'b1;
      end
      if (push_ok) begin
        wp <= wp + 1'b1;
      end
      if (push_drop) begin
        overflow <= 1'b1;
      end
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_btn_input_fifo.sv
// Directed bench for btn_input_fifo: press timing, bounce,
// overflow, full push+pop, empty read, clear and async reset.
module tb_btn_input_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_push;
  logic        btn_clear;
  logic [3:0]  sw;
  logic        rd_req;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic        empty;
  logic        full;
  logic [2:0]  count;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  btn_input_fifo dut (
    .clk       (clk),
    .rst       (rst),
    .btn_push  (btn_push),
    .btn_clear (btn_clear),
    .sw        (sw),
    .rd_req    (rd_req),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] v);
    sw       = v;
    btn_push = 1'b1;
    tick(8);
    btn_push = 1'b0;
    tick(8);
  endtask

  task automatic pop_check(input string tag, input logic [15:0] exp);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"}, 32'(rd_data), 32'(exp));
    tick();
    check({tag, "_strobe"}, 32'(rd_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    btn_push  = 1'b0;
    btn_clear = 1'b0;
    sw        = 4'h0;
    rd_req    = 1'b0;
    tick(2);
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    rst = 1'b0;
    tick(2);

    // 1: latency of a clean press
    sw       = 4'h5;
    btn_push = 1'b1;
    tick(6);
    check("t1_early", 32'(count), 32'd0);
    tick();
    check("t1_count", 32'(count), 32'd1);
    check("t1_nempty", 32'(empty), 32'd0);
    tick(2);
    btn_push = 1'b0;
    tick(8);
    pop_check("t1_pop", 16'h0005);
    check("t1_empty", 32'(empty), 32'd1);

    // 2: 3-cycle bounces are ignored, 4-cycle press accepted
    sw = 4'h6;
    for (int k = 0; k < 3; k++) begin
      btn_push = 1'b1;
      tick(3);
      btn_push = 1'b0;
      tick(3);
    end
    tick(6);
    check("t2_bounce", 32'(count), 32'd0);
    btn_push = 1'b1;
    tick(4);
    btn_push = 1'b0;
    tick(10);
    check("t2_one_evt", 32'(count), 32'd1);
    pop_check("t2_pop", 16'h0006);

    // 3: fill, overflow, drain in order
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    check("t3_full", 32'(full), 32'd1);
    check("t3_ovf0", 32'(overflow), 32'd0);
    press(4'h9);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_count", 32'(count), 32'd4);
    pop_check("t3_p1", 16'h0001);
    pop_check("t3_p2", 16'h0002);
    pop_check("t3_p3", 16'h0003);
    pop_check("t3_p4", 16'h0004);
    check("t3_empty", 32'(empty), 32'd1);

    // flush the sticky overflow before the full push+pop case
    btn_clear = 1'b1;
    tick(8);
    btn_clear = 1'b0;
    tick(8);
    check("t3_clr_ovf", 32'(overflow), 32'd0);

    // 4: full FIFO, push event and pop in the same cycle
    press(4'ha);
    press(4'hb);
    press(4'hc);
    press(4'hd);
    check("t4_full", 32'(full), 32'd1);
    sw       = 4'he;
    btn_push = 1'b1;
    tick(6);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("t4_valid", 32'(rd_valid), 32'd1);
    check("t4_data", 32'(rd_data), 32'h000a);
    check("t4_count", 32'(count), 32'd4);
    check("t4_ovf", 32'(overflow), 32'd0);
    tick();
    btn_push = 1'b0;
    tick(8);
    pop_check("t4_p1", 16'h000b);
    pop_check("t4_p2", 16'h000c);
    pop_check("t4_p3", 16'h000d);
    pop_check("t4_p4", 16'h000e);

    // 5: read while empty gives no response
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("t5_valid", 32'(rd_valid), 32'd0);
      check("t5_data", 32'(rd_data), 32'h000e);
      tick();
    end
    check("t5_count", 32'(count), 32'd0);

    // 6: two entries with overflow set, then clear
    press(4'h6);
    press(4'h7);
    press(4'h8);
    press(4'h9);
    press(4'h3);
    pop_check("t6_p1", 16'h0006);
    pop_check("t6_p2", 16'h0007);
    check("t6_count2", 32'(count), 32'd2);
    check("t6_ovf1", 32'(overflow), 32'd1);
    btn_clear = 1'b1;
    tick(8);
    check("t6_count", 32'(count), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_empty", 32'(empty), 32'd1);
    btn_clear = 1'b0;
    tick(8);

    // async reset in the middle of a debounce
    press(4'h2);
    check("t6_pre_rst", 32'(count), 32'd1);
    sw       = 4'h4;
    btn_push = 1'b1;
    tick(3);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_empty", 32'(empty), 32'd1);
    check("t6_rst_data", 32'(rd_data), 32'd0);
    check("t6_rst_valid", 32'(rd_valid), 32'd0);
    check("t6_rst_full", 32'(full), 32'd0);
    check("t6_rst_ovf", 32'(overflow), 32'd0);
    btn_push = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(10);
    check("t6_post_rst", 32'(count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
